// File: rtl/seq_shift_right_if.sv
// Request/response bundle for the iterative right shifter.
// master drives the operation request; slave returns status and result.
interface seq_shift_right_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
);
   logic               start;
   logic               arith;
   logic [WIDTH-1:0]   a;
   logic [SHAMT_W-1:0] shamt;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, arith, a, shamt,
      input  busy, done, result
   );

   modport slave (
      input  start, arith, a, shamt,
      output busy, done, result
   );
endinterface

// File: rtl/seq_shift_right.sv
// Iterative SRL/SRA unit: one bit per clock under a start/done handshake.
// Optional macro SHR_RADIX4_EN adds 4-bit steps while at least 4 bits remain.
module seq_shift_right #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input logic               clk,
   input logic               rst,
   seq_shift_right_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   sr;
   logic [SHAMT_W-1:0] cnt;
   logic               f;
   logic               busy_q;
   logic               done_q;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = sr;

   // State, datapath and registered status flags advance together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sr     <= '0;
         cnt    <= '0;
         f      <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  sr  <= bus.a;
                  cnt <= bus.shamt;
                  f   <= bus.arith & bus.a[WIDTH-1];
                  if (bus.shamt != '0) begin
                     state  <= SHIFT;
                     busy_q <= 1'b1;
                     done_q <= 1'b0;
                  end else begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            end

            SHIFT: begin
`ifdef SHR_RADIX4_EN
               // Coarse step while at least four positions remain.
               if (cnt >= SHAMT_W'(4)) begin
                  sr  <= {{4{f}}, sr[WIDTH-1:4]};
                  cnt <= cnt - SHAMT_W'(4);
                  if (cnt == SHAMT_W'(4)) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end else begin
                  sr  <= {f, sr[WIDTH-1:1]};
                  cnt <= cnt - SHAMT_W'(1);
                  if (cnt == SHAMT_W'(1)) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
`else
               sr  <= {f, sr[WIDTH-1:1]};
               cnt <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
`endif
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_right.sv
// Self-checking bench for seq_shift_right against an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_shift_right;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SHAMT_W = 5;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   seq_shift_right_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

   seq_shift_right #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] exp_result(input logic [WIDTH-1:0] a,
                                                   input int sh, input logic ar);
      logic signed [WIDTH-1:0] s;
      s = $signed(a);
      if (ar) return WIDTH'(s >>> sh);
      return a >> sh;
   endfunction

   function automatic int exp_lat(input int sh);
`ifdef SHR_RADIX4_EN
      return sh / 4 + sh % 4 + 1;
`else
      return sh + 1;
`endif
   endfunction

   task automatic start_op(input logic [WIDTH-1:0] a, input int sh, input logic ar);
      bus.start = 1'b1;
      bus.a     = a;
      bus.shamt = SHAMT_W'(sh);
      bus.arith = ar;
   endtask

   // Returns the cycle index of done (0 on timeout) and the number of busy cycles seen.
   task automatic wait_done(output int cycles, output int busy_cycles);
      cycles = 0;
      busy_cycles = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b result=%h required 0 0 00000000",
                  bus.busy, bus.done, bus.result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_logical();
      int cyc, bc;
      start_op(32'h8000_0000, 3, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== exp_lat(3)) begin
         n_err++;
         $display("FAIL logical_latency: got %0d required %0d", cyc, exp_lat(3));
      end
      n_cmp++;
      if (bc !== exp_lat(3) - 1) begin
         n_err++;
         $display("FAIL logical_busy: got %0d required %0d", bc, exp_lat(3) - 1);
      end
      n_cmp++;
      if (bus.result !== 32'h1000_0000) begin
         n_err++;
         $display("FAIL logical_result: got %h required 10000000", bus.result);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.result !== 32'h1000_0000) begin
         n_err++;
         $display("FAIL done_pulse_hold: done=%b result=%h required 0 10000000",
                  bus.done, bus.result);
      end
   endtask

   task automatic test_arith_max();
      int cyc, bc;
      start_op(32'h8000_0000, 31, 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== exp_lat(31)) begin
         n_err++;
         $display("FAIL arith_max_latency: got %0d required %0d", cyc, exp_lat(31));
      end
      n_cmp++;
      if (bus.result !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL arith_max_result: got %h required ffffffff", bus.result);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      start_op(32'hF0F0_F0F0, 0, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 1 || bus.result !== 32'hF0F0_F0F0) begin
         n_err++;
         $display("FAIL zero_shift: cycles=%0d result=%h required 1 f0f0f0f0", cyc, bus.result);
      end
      start_op(32'h0000_FFFF, 8, 1'b1);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== exp_lat(8) || bus.result !== 32'h0000_00FF) begin
         n_err++;
         $display("FAIL back_to_back: cycles=%0d result=%h required %0d 000000ff",
                  cyc, bus.result, exp_lat(8));
      end
      @(negedge clk);
   endtask

   task automatic test_start_during_busy();
      int dones = 0;
      logic [WIDTH-1:0] res = '0;
      start_op(32'hFFFF_0000, 10, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         bus.start = (i == 2 || i == 3);
         if (i == 2) begin
            bus.a     = 32'h1234_5678;
            bus.shamt = SHAMT_W'(1);
            bus.arith = 1'b0;
         end
         if (bus.done) begin
            dones++;
            res = bus.result;
         end
      end
      n_cmp++;
      if (dones !== 1 || res !== exp_result(32'hFFFF_0000, 10, 1'b1)) begin
         n_err++;
         $display("FAIL start_during_busy: dones=%0d result=%h required 1 %h",
                  dones, res, exp_result(32'hFFFF_0000, 10, 1'b1));
      end
   endtask

   task automatic test_reset_mid_op();
      int cyc, bc;
      int dones = 0;
      start_op(32'hFFFF_0000, 20, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
         n_err++;
         $display("FAIL reset_mid_op: busy=%b done=%b result=%h required 0 0 00000000",
                  bus.busy, bus.done, bus.result);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin
         n_err++;
         $display("FAIL reset_no_done: done pulses=%0d required 0", dones);
      end
      start_op(32'h0000_0010, 4, 1'b0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== exp_lat(4) || bus.result !== 32'h0000_0001) begin
         n_err++;
         $display("FAIL after_reset_op: cycles=%0d result=%h required %0d 00000001",
                  cyc, bus.result, exp_lat(4));
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int cyc, bc, sh;
      logic [WIDTH-1:0] a;
      logic ar;
      for (int k = 0; k < 40; k++) begin
         a  = $urandom;
         sh = int'($urandom_range(0, WIDTH - 1));
         ar = 1'($urandom_range(0, 1));
         start_op(a, sh, ar);
         wait_done(cyc, bc);
         n_cmp++;
         if (cyc !== exp_lat(sh) || bc !== exp_lat(sh) - 1 || bus.result !== exp_result(a, sh, ar)) begin
            n_err++;
            $display("FAIL random_op a=%h sh=%0d ar=%b: cycles=%0d busy=%0d result=%h required %0d %0d %h",
                     a, sh, ar, cyc, bc, bus.result, exp_lat(sh), exp_lat(sh) - 1,
                     exp_result(a, sh, ar));
         end
         // Alternate between idle gaps and back-to-back issue from DONE.
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.arith = 1'b0;
      bus.a     = '0;
      bus.shamt = '0;
      @(negedge clk);
      test_reset();
      test_logical();
      test_arith_max();
      test_back_to_back();
      test_start_during_busy();
      test_reset_mid_op();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Iterative right-shift unit for the execute stage. Implements SRL/SRLI and SRA/SRAI.
- Complements the combinational left shifter used for branch offsets. It shifts the opposite direction, one bit per clock, under a start/done handshake.
- Sits beside the ALU. Control holds the pipeline while busy is high and captures the result on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; sampled on rising edge of clk.
- arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); sampled with start.
- a  input  WIDTH  operand; sampled with start.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; sampled with start.
- busy  output  1  high while shifting (state SHIFT).
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; stable from done until the next accepted start.

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - rst is asynchronous and active-high.
  - While rst is high: state=IDLE, busy=0, done=0, result=0, internal count=0, latched fill bit=0.
- Registers:
  - Shift register sr drives result directly.
  - Down-counter cnt is SHAMT_W bits wide.
  - Fill bit f.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: sr<=a, cnt<=shamt, f<=arith & a[WIDTH-1].
  - Next state is SHIFT if shamt!=0, else DONE.
  - On start=0: remain in IDLE.
- SHIFT:
  - Each clock: sr<={f, sr[WIDTH-1:1]}, cnt<=cnt-1.
  - When cnt==1 at the edge, the final shift occurs and the next state is DONE.
  - start is ignored in SHIFT. No queueing, no effect on sr/cnt/f.
- DONE:
  - done=1 for exactly this cycle.
  - With start=0: next state is IDLE.
  - With start=1: accepted exactly as in IDLE (back-to-back ops). done still pulses this cycle and the new operand loads at the edge.
- Outputs:
  - busy=1 iff state==SHIFT.
  - done=1 iff state==DONE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(shamt), i.e. shamt+1 cycles after the start cycle.
  - shamt=0 gives 1 cycle, result=a.
  - shamt=WIDTH-1 gives WIDTH cycles.
- result during SHIFT is intermediate and not valid. After DONE it holds sr until the next accepted start.
- Arithmetic:
  - Pure bit movement; no overflow.
  - Sign taken from a[WIDTH-1] at the accept cycle.
  - arith=1 with a[WIDTH-1]=0 behaves as logical.
- cnt never wraps: SHIFT is entered only with cnt>=1 and exits at cnt==1.
- Reset mid-operation aborts immediately: outputs return to reset values and no done pulse occurs.

Optional Feature:
- Macro SHR_RADIX4_EN.
- Defined:
  - In SHIFT, when cnt>=4: sr<={{4{f}}, sr[WIDTH-1:4]}, cnt<=cnt-4.
  - Otherwise the 1-bit step applies.
  - SHIFT exits when the step brings cnt to 0.
  - Latency = floor(shamt/4) + (shamt mod 4) + 1.
- Undefined: 1 bit per cycle only; latency = shamt+1.
- Results are identical either way.

Test Plan:
- Reset: assert rst mid-idle -> busy=0, done=0, result=0x00000000.
- Logical shift: start, a=0x80000000, shamt=3, arith=0 -> busy 3 cycles, done in cycle 4, result=0x10000000. Radix4 build: done in cycle 4.
- Arithmetic max shift: a=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF, done in cycle 32. Radix4 build: done in cycle 11.
- Zero shift then back-to-back:
  - a=0xF0F0F0F0, shamt=0 -> done in cycle 1, result=0xF0F0F0F0.
  - start held in the DONE cycle with a=0x0000FFFF, shamt=8, arith=1 -> next done gives result=0x000000FF.
- Start during busy: start pulses while busy with a=0x12345678 -> ignored; original op completes with its own result; one done pulse.
- Reset mid-op: a=0xFFFF0000, shamt=20, assert rst at cycle 5 -> outputs reset immediately, no done. After release, a new op shamt=4, a=0x00000010 -> result=0x00000001.
